uart_block_assembler: RTL and testbench

- Upstream stage of the softmax UART top.
- Collects the byte stream from the UART receiver into a fixed-size block buffer: 1 length byte plus 64 little-endian 16-bit words, so 129 bytes.
- When the block is full it raises block_ready and exposes the block through an asynchronous random-read port.
- It holds the block until the consumer pulses consume; bytes arriving while it holds a block are dropped and flagged as overrun.

---
 rtl/uart_block_assembler.sv | 184 ++++++++++++++++++
 tb/tb_uart_block_assembler.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/uart_block_assembler.sv
// Collects UART bytes into a BLOCK_SIZE-byte buffer and holds it for a consumer with an async read port.
// Optional macro RX_IDLE_RESYNC_EN: discard a partial block after IDLE_TIMEOUT cycles of rx silence.
module uart_block_assembler #(
  parameter int BLOCK_SIZE   = 129,
  parameter int IDLE_TIMEOUT = 1000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  input  logic       consume,
  output logic       block_ready,
  output logic [7:0] byte_count,
  output logic       overrun,
  input  logic [7:0] rd_addr,
  output logic [7:0] rd_data
);

  typedef enum logic [0:0] {
    S_FILL = 1'b0,
    S_FULL = 1'b1
  } state_e;

  localparam logic [7:0] SIZE_B = 8'(BLOCK_SIZE);
  localparam logic [7:0] LAST_B = 8'(BLOCK_SIZE - 1);

  if (BLOCK_SIZE < 2 || BLOCK_SIZE > 255) begin : g_bad_block_size
    $error("uart_block_assembler: BLOCK_SIZE must be within 2..255");
  end
  if (IDLE_TIMEOUT < 2) begin : g_bad_idle_timeout
    $error("uart_block_assembler: IDLE_TIMEOUT must be at least 2");
  end

  state_e     state_q, state_d;
  logic [7:0] wr_ptr_q, wr_ptr_d;
  logic [7:0] byte_count_q, byte_count_d;
  logic       overrun_q, overrun_d;
  logic       wr_en_s;
  logic [7:0] mem_q [BLOCK_SIZE];

`ifdef RX_IDLE_RESYNC_EN
  localparam int IDLE_W = $clog2(IDLE_TIMEOUT);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_TIMEOUT - 1);
  logic [IDLE_W-1:0] idle_q, idle_d;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FILL;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FILL: begin
        if (rx_valid && (byte_count_q == LAST_B)) begin
          state_d = S_FULL;
        end else begin
          state_d = S_FILL;
        end
      end
      S_FULL: begin
        if (consume) begin
          state_d = S_FILL;
        end else begin
          state_d = S_FULL;
        end
      end
      default: state_d = S_FILL;
    endcase
  end

  // FSM outputs
  always_comb begin
    block_ready = 1'b0;
    case (state_q)
      S_FILL:  block_ready = 1'b0;
      S_FULL:  block_ready = 1'b1;
      default: block_ready = 1'b0;
    endcase
  end

  // Datapath next-state: write pointer, count, overrun flag and idle counter
  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    byte_count_d = byte_count_q;
    overrun_d    = overrun_q;
    wr_en_s      = 1'b0;
`ifdef RX_IDLE_RESYNC_EN
    idle_d       = {IDLE_W{1'b0}};
`endif
    case (state_q)
      S_FILL: begin
        if (rx_valid) begin
          wr_en_s      = 1'b1;
          wr_ptr_d     = wr_ptr_q + 8'd1;
          byte_count_d = byte_count_q + 8'd1;
        end
`ifdef RX_IDLE_RESYNC_EN
        else if (byte_count_q != 8'd0) begin
          // Silence on a partial block: assume a framing slip and restart once it lasts too long
          if (idle_q == IDLE_LAST) begin
            byte_count_d = 8'd0;
            wr_ptr_d     = 8'd0;
            idle_d       = {IDLE_W{1'b0}};
          end else begin
            idle_d = idle_q + IDLE_W'(1);
          end
        end else begin
          idle_d = {IDLE_W{1'b0}};
        end
`else
        else begin
          wr_en_s = 1'b0;
        end
`endif
      end
      S_FULL: begin
        if (consume) begin
          wr_ptr_d     = 8'd0;
          byte_count_d = 8'd0;
          overrun_d    = 1'b0;
        end else begin
          byte_count_d = SIZE_B;
        end
        // A byte arriving with the release is still dropped, so the set wins over the clear
        if (rx_valid) begin
          overrun_d = 1'b1;
        end else begin
          overrun_d = overrun_d;
        end
      end
      default: begin
        wr_ptr_d     = 8'd0;
        byte_count_d = 8'd0;
      end
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q     <= 8'd0;
      byte_count_q <= 8'd0;
      overrun_q    <= 1'b0;
`ifdef RX_IDLE_RESYNC_EN
      idle_q       <= {IDLE_W{1'b0}};
`endif
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      byte_count_q <= byte_count_d;
      overrun_q    <= overrun_d;
`ifdef RX_IDLE_RESYNC_EN
      idle_q       <= idle_d;
`endif
    end
  end

  // Block storage write port (contents intentionally not reset)
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_q[wr_ptr_q] <= rx_data;
    end
  end

  // Asynchronous read port; out-of-range addresses read as zero
  always_comb begin
    rd_data = 8'h00;
    if (rd_addr < SIZE_B) begin
      rd_data = mem_q[rd_addr];
    end else begin
      rd_data = 8'h00;
    end
  end

  assign byte_count = byte_count_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_uart_block_assembler.sv
// Directed plus randomized bench for uart_block_assembler against a transaction-level block model.
module tb_uart_block_assembler;

  localparam int BS   = 129;
  localparam int IDLE = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       consume;
  logic       block_ready;
  logic [7:0] byte_count;
  logic       overrun;
  logic [7:0] rd_addr;
  logic [7:0] rd_data;

  int total = 0;
  int bad   = 0;

  logic [7:0] ref_mem [256];
  int         ref_count;
  bit         ref_full;
  bit         ref_over;
  int         ref_idle;

  uart_block_assembler #(.BLOCK_SIZE(BS), .IDLE_TIMEOUT(IDLE)) dut (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data), .consume(consume),
    .block_ready(block_ready), .byte_count(byte_count), .overrun(overrun),
    .rd_addr(rd_addr), .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock of stimulus; the model applies the block rules at transaction level
  task automatic tick(input logic v, input logic [7:0] d, input logic c);
    rx_valid = v; rx_data = d; consume = c;
    @(posedge clk); #1;
    rx_valid = 1'b0; consume = 1'b0;
    if (ref_full) begin
      if (c) begin ref_full = 1'b0; ref_count = 0; ref_over = 1'b0; end
      if (v) ref_over = 1'b1;
      ref_idle = 0;
    end else if (v) begin
      ref_mem[ref_count] = d;
      ref_count++;
      ref_idle = 0;
      if (ref_count == BS) ref_full = 1'b1;
    end else begin
`ifdef RX_IDLE_RESYNC_EN
      if (ref_count != 0) begin
        ref_idle++;
        if (ref_idle == IDLE) begin ref_count = 0; ref_idle = 0; end
      end else begin
        ref_idle = 0;
      end
`endif
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    ref_count = 0; ref_full = 1'b0; ref_over = 1'b0; ref_idle = 0;
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".ready"}, {31'd0, block_ready}, {31'd0, ref_full});
    chk({tag, ".count"}, {24'd0, byte_count}, 32'(ref_count));
    chk({tag, ".overrun"}, {31'd0, overrun}, {31'd0, ref_over});
  endtask

  task automatic rd(input int a, input logic [7:0] exp, input string tag);
    rd_addr = 8'(a);
    #1;
    chk(tag, {24'd0, rd_data}, {24'd0, exp});
  endtask

  initial begin
    logic [7:0] b;
    int a;
    int r;
    rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; consume = 1'b0; rd_addr = 8'h00;
    @(posedge clk); #1;
    do_reset();
    chk("reset.ready", {31'd0, block_ready}, 32'd0);
    chk("reset.count", {24'd0, byte_count}, 32'd0);
    chk("reset.overrun", {31'd0, overrun}, 32'd0);

    // Full block of index bytes
    for (int i = 0; i < BS; i++) begin
      tick(1'b1, 8'(i), 1'b0);
      if (i == BS - 2) begin
        chk("fill.ready_early", {31'd0, block_ready}, 32'd0);
        chk("fill.count128", {24'd0, byte_count}, 32'd128);
      end
    end
    chk("full.ready", {31'd0, block_ready}, 32'd1);
    chk("full.count", {24'd0, byte_count}, 32'd129);
    rd(0, 8'h00, "rd.addr0");
    rd(128, 8'h80, "rd.addr128");
    rd(200, 8'h00, "rd.addr200");
    for (int i = 0; i < BS; i++) rd(i, ref_mem[i], "rd.sweep1");

    // Overrun while held, then release
    tick(1'b1, 8'hF0, 1'b0);
    chk("ovr.set", {31'd0, overrun}, 32'd1);
    tick(1'b1, 8'hF1, 1'b0);
    tick(1'b1, 8'hF2, 1'b0);
    rd(5, 8'h05, "ovr.protect");
    chk("ovr.count", {24'd0, byte_count}, 32'd129);
    tick(1'b0, 8'h00, 1'b1);
    chk("rel.ready", {31'd0, block_ready}, 32'd0);
    chk("rel.count", {24'd0, byte_count}, 32'd0);
    chk("rel.overrun", {31'd0, overrun}, 32'd0);
    rd(7, 8'h07, "rel.stale_readable");

    // Simultaneous consume and rx_valid
    for (int i = 0; i < BS; i++) tick(1'b1, 8'($urandom), 1'b0);
    chk("sim.full", {31'd0, block_ready}, 32'd1);
    tick(1'b1, 8'hAA, 1'b1);
    chk("sim.ready", {31'd0, block_ready}, 32'd0);
    chk("sim.count", {24'd0, byte_count}, 32'd0);
    chk("sim.overrun", {31'd0, overrun}, 32'd1);
    tick(1'b1, 8'h11, 1'b0);
    rd(0, 8'h11, "sim.next_addr0");
    chk("sim.next_count", {24'd0, byte_count}, 32'd1);

    // Reset mid-fill then refill with 8'h5A
    for (int i = 1; i < 50; i++) tick(1'b1, 8'($urandom), 1'b0);
    chk("mid.count50", {24'd0, byte_count}, 32'd50);
    do_reset();
    chk("mid.reset_count", {24'd0, byte_count}, 32'd0);
    chk("mid.reset_ready", {31'd0, block_ready}, 32'd0);
    chk("mid.reset_overrun", {31'd0, overrun}, 32'd0);
    for (int i = 0; i < BS - 1; i++) tick(1'b1, 8'h5A, 1'b0);
    chk("5a.not_ready", {31'd0, block_ready}, 32'd0);
    tick(1'b1, 8'h5A, 1'b0);
    chk("5a.ready", {31'd0, block_ready}, 32'd1);
    for (int i = 0; i < BS; i++) rd(i, 8'h5A, "5a.sweep");
    tick(1'b0, 8'h00, 1'b1);

    // Consume while filling is ignored
    for (int i = 0; i < 10; i++) tick(1'b1, 8'($urandom), 1'b0);
    tick(1'b0, 8'h00, 1'b1);
    chk("fillcons.count", {24'd0, byte_count}, 32'd10);
    chk("fillcons.ready", {31'd0, block_ready}, 32'd0);

    // Idle behaviour on a partial block
    do_reset();
    for (int i = 0; i < 7; i++) tick(1'b1, 8'($urandom), 1'b0);
`ifdef RX_IDLE_RESYNC_EN
    for (int i = 0; i < IDLE - 1; i++) tick(1'b0, 8'h00, 1'b0);
    chk("idle15.count", {24'd0, byte_count}, 32'd7);
    tick(1'b1, 8'h33, 1'b0);
    chk("idle15.byte", {24'd0, byte_count}, 32'd8);
    do_reset();
    for (int i = 0; i < 7; i++) tick(1'b1, 8'($urandom), 1'b0);
    for (int i = 0; i < IDLE; i++) tick(1'b0, 8'h00, 1'b0);
    chk("idle16.count", {24'd0, byte_count}, 32'd0);
`else
    for (int i = 0; i < 40; i++) tick(1'b0, 8'h00, 1'b0);
    chk("idle.hold", {24'd0, byte_count}, 32'd7);
`endif
    chk_model("idle.model");

    // Randomized traffic against the model
    do_reset();
    for (int n = 0; n < 1500; n++) begin
      r = int'($urandom_range(0, 9));
      b = 8'($urandom);
      if (r <= 6)      tick(1'b1, b, 1'b0);
      else if (r == 7) tick(1'b0, 8'h00, 1'b1);
      else if (r == 8) tick(1'b1, b, 1'b1);
      else             tick(1'b0, 8'h00, 1'b0);
      chk_model("rand");
      if (ref_full || ref_count > 0) begin
        a = int'($urandom_range(0, (ref_full ? BS : ref_count) - 1));
        rd(a, ref_mem[a], "rand.rd");
      end
      if ((n % 50) == 0) rd(int'($urandom_range(BS, 255)), 8'h00, "rand.rd_oob");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
